// File: rtl/serial_parity_rx.sv
// Serial frame receiver: start(0), N data bits LSB-first, parity, stop(1).
// Recomputes parity over the received word and reports parity and framing errors.
module serial_parity_rx #(
    parameter int N   = 8,
    parameter bit ODD = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         bit_en,
    input  logic         rx_bit,
    output logic [N-1:0] data,
    output logic         valid,
    output logic         parity_err,
    output logic         frame_err,
    output logic         busy
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // Parity bit the transmitter should have sent for this word.
    function automatic logic expected_parity(input logic [N-1:0] word);
        logic p;
        if (ODD) begin
            p = ~^word;
        end else begin
            p = ^word;
        end
        return p;
    endfunction

    state_t         state_r, state_s;
    logic [N-1:0]   shift_r, shift_s;
    logic [CW-1:0]  count_r, count_s;
    logic           par_r, par_s;
    logic [N-1:0]   data_r, data_s;
    logic           valid_r, valid_s;
    logic           parity_err_r, parity_err_s;
    logic           frame_err_r, frame_err_s;

    // Next-state and next-output logic; everything advances only on bit_en.
    always_comb begin
        state_s      = state_r;
        shift_s      = shift_r;
        count_s      = count_r;
        par_s        = par_r;
        data_s       = data_r;
        valid_s      = 1'b0;
        parity_err_s = parity_err_r;
        frame_err_s  = frame_err_r;
        if (bit_en) begin
            case (state_r)
                IDLE: begin
                    if (!rx_bit) begin
                        state_s = DATA;
                        count_s = CNT_ZERO;
                        shift_s = {N{1'b0}};
                    end else begin
                        state_s = IDLE;
                    end
                end
                DATA: begin
                    // Shifting in at the MSB leaves the first bit at the LSB after N bits.
                    shift_s = {rx_bit, shift_r[N-1:1]};
                    if (count_r == CNT_LAST) begin
                        state_s = PARITY;
                    end else begin
                        state_s = DATA;
                    end
                    count_s = count_r + CNT_ONE;
                end
                PARITY: begin
                    par_s   = rx_bit;
                    state_s = STOP;
                end
                STOP: begin
                    data_s       = shift_r;
                    valid_s      = 1'b1;
                    parity_err_s = (par_r != expected_parity(shift_r));
                    frame_err_s  = ~rx_bit;
                    state_s      = IDLE;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State and output registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            shift_r      <= {N{1'b0}};
            count_r      <= CNT_ZERO;
            par_r        <= 1'b0;
            data_r       <= {N{1'b0}};
            valid_r      <= 1'b0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            shift_r      <= shift_s;
            count_r      <= count_s;
            par_r        <= par_s;
            data_r       <= data_s;
            valid_r      <= valid_s;
            parity_err_r <= parity_err_s;
            frame_err_r  <= frame_err_s;
        end
    end

    assign data       = data_r;
    assign valid      = valid_r;
    assign parity_err = parity_err_r;
    assign frame_err  = frame_err_r;
    assign busy       = (state_r != IDLE);

endmodule

// File: tb/tb_serial_parity_rx.sv
// Directed and randomized bench for serial_parity_rx: an N=8 even-parity and an
// N=5 odd-parity instance checked against a frame-level reference model.
module tb_serial_parity_rx;

    logic       clk;
    logic       rst;
    logic       en8, rx8, en5, rx5;
    logic [7:0] data8;
    logic [4:0] data5;
    logic       valid8, perr8, ferr8, busy8;
    logic       valid5, perr5, ferr5, busy5;

    int checks   = 0;
    int failures = 0;

    serial_parity_rx #(.N(8), .ODD(1'b0)) dut8 (
        .clk(clk), .rst(rst), .bit_en(en8), .rx_bit(rx8),
        .data(data8), .valid(valid8), .parity_err(perr8), .frame_err(ferr8), .busy(busy8)
    );

    serial_parity_rx #(.N(5), .ODD(1'b1)) dut5 (
        .clk(clk), .rst(rst), .bit_en(en5), .rx_bit(rx5),
        .data(data5), .valid(valid5), .parity_err(perr5), .frame_err(ferr5), .busy(busy5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Parity bit a correct transmitter sends: total ones even (odd=0) or odd (odd=1).
    function automatic logic model_parity(input logic [31:0] w, input int n, input bit odd);
        int ones = 0;
        for (int i = 0; i < n; i++) begin
            if (w[i]) ones++;
        end
        return ((ones % 2) == 1) ^ odd;
    endfunction

    function automatic logic [31:0] get_data(input bit sel);
        return sel ? {27'b0, data5} : {24'b0, data8};
    endfunction
    function automatic logic get_valid(input bit sel); return sel ? valid5 : valid8; endfunction
    function automatic logic get_perr(input bit sel);  return sel ? perr5  : perr8;  endfunction
    function automatic logic get_ferr(input bit sel);  return sel ? ferr5  : ferr8;  endfunction
    function automatic logic get_busy(input bit sel);  return sel ? busy5  : busy8;  endfunction

    // Drive one cycle on the selected instance, then sample 1 ns after the edge.
    task automatic tick(input bit sel, input logic b, input logic en);
        if (sel) begin
            rx5 = b; en5 = en; rx8 = 1'b1; en8 = 1'b0;
        end else begin
            rx8 = b; en8 = en; rx5 = 1'b1; en5 = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bit sel, input logic [31:0] word, input logic p,
                              input logic stop, input bit gapped, input string tag);
        int          n = sel ? 5 : 8;
        logic        bits[$];
        logic        exp_perr;
        logic [31:0] prev_data;
        logic        prev_perr, prev_ferr;
        prev_data = get_data(sel);
        prev_perr = get_perr(sel);
        prev_ferr = get_ferr(sel);
        bits.push_back(1'b0);
        for (int i = 0; i < n; i++) bits.push_back(word[i]);
        bits.push_back(p);
        bits.push_back(stop);
        exp_perr = (p != model_parity(word, n, sel));
        for (int k = 0; k < bits.size(); k++) begin
            tick(sel, bits[k], 1'b1);
            if (k < bits.size() - 1) begin
                check_bit({tag, "_busy_mid"}, get_busy(sel), 1'b1);
                check_bit({tag, "_valid_mid"}, get_valid(sel), 1'b0);
                check({tag, "_data_mid"}, get_data(sel), prev_data);
                if (gapped) begin
                    for (int g = 0; g < 2; g++) begin
                        tick(sel, 1'($urandom_range(1, 0)), 1'b0);
                        check_bit({tag, "_busy_gap"}, get_busy(sel), 1'b1);
                        check_bit({tag, "_valid_gap"}, get_valid(sel), 1'b0);
                    end
                end
            end
        end
        check_bit({tag, "_valid"}, get_valid(sel), 1'b1);
        check({tag, "_data"}, get_data(sel), word);
        check_bit({tag, "_perr"}, get_perr(sel), exp_perr);
        check_bit({tag, "_ferr"}, get_ferr(sel), ~stop);
        check_bit({tag, "_busy_end"}, get_busy(sel), 1'b0);
        // Valid lasts one cycle even with bit_en low; results are held.
        tick(sel, 1'b0, 1'b0);
        check_bit({tag, "_valid_drop"}, get_valid(sel), 1'b0);
        check({tag, "_data_hold"}, get_data(sel), word);
        check_bit({tag, "_perr_hold"}, get_perr(sel), exp_perr);
        check_bit({tag, "_ferr_hold"}, get_ferr(sel), ~stop);
        if (prev_perr === 1'bx || prev_ferr === 1'bx) begin
            check_bit({tag, "_prev_known"}, 1'b0, 1'b1);
        end
    endtask

    initial begin
        logic [31:0] w;
        logic        p, stop;
        bit          sel, gapped;
        rst = 1'b1; en8 = 1'b0; rx8 = 1'b1; en5 = 1'b0; rx5 = 1'b1;

        // Reset with a start bit presented: reset wins.
        rx8 = 1'b0; en8 = 1'b1; rx5 = 1'b0; en5 = 1'b1;
        @(posedge clk); #1;
        check_bit("rst_busy8", busy8, 1'b0);
        check_bit("rst_valid8", valid8, 1'b0);
        check("rst_data8", {24'b0, data8}, 32'h0);
        check_bit("rst_perr8", perr8, 1'b0);
        check_bit("rst_ferr8", ferr8, 1'b0);
        check_bit("rst_busy5", busy5, 1'b0);
        check("rst_data5", {27'b0, data5}, 32'h0);
        rst = 1'b0;
        tick(1'b0, 1'b1, 1'b1);
        check_bit("idle_busy8", busy8, 1'b0);

        send_frame(1'b0, 32'h03, 1'b0, 1'b1, 1'b0, "t1_clean");
        send_frame(1'b0, 32'h03, 1'b1, 1'b1, 1'b0, "t2_badpar");
        send_frame(1'b0, 32'h03, 1'b0, 1'b1, 1'b0, "t2_clear");
        send_frame(1'b0, 32'hA5, 1'b0, 1'b0, 1'b0, "t3_frameerr");
        send_frame(1'b0, 32'h3C, 1'b0, 1'b1, 1'b0, "t3_restart");
        send_frame(1'b0, 32'h5A, 1'b0, 1'b1, 1'b1, "t4_gapped");

        // Reset after the 4th data bit discards the partial frame.
        tick(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b1);
        check_bit("t5_busy_pre", busy8, 1'b1);
        rst = 1'b1;
        tick(1'b0, 1'b1, 1'b1);
        rst = 1'b0;
        check_bit("t5_busy", busy8, 1'b0);
        check_bit("t5_valid", valid8, 1'b0);
        check("t5_data", {24'b0, data8}, 32'h0);
        check_bit("t5_perr", perr8, 1'b0);
        tick(1'b0, 1'b1, 1'b1);
        check_bit("t5_novalid", valid8, 1'b0);
        send_frame(1'b0, 32'hFF, 1'b0, 1'b1, 1'b0, "t5_ff");

        send_frame(1'b1, 32'h07, 1'b0, 1'b1, 1'b0, "t6_odd_ok");
        send_frame(1'b1, 32'h07, 1'b1, 1'b1, 1'b0, "t6_odd_bad");

        for (int r = 0; r < 30; r++) begin
            sel    = 1'($urandom_range(1, 0));
            w      = sel ? 32'($urandom_range(31, 0)) : 32'($urandom_range(255, 0));
            p      = 1'($urandom_range(1, 0));
            stop   = ($urandom_range(3, 0) != 0) ? 1'b1 : 1'b0;
            gapped = 1'($urandom_range(1, 0));
            send_frame(sel, w, p, stop, gapped, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
